// File: rtl/mem_if_pkg.sv
// Shared cache/memory interface definitions: default widths, fill-line geometry
// and the response record carried from the memory back to the cache.
package mem_if_pkg;

   localparam int DEF_ADDR_W  = 16;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_LATENCY = 4;

   // A cache line is 8 words; the byte offset within a line spans 4 address bits.
   localparam int WORDS_PER_LINE = 8;
   localparam int LINE_OFFSET_W  = 4;

   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] addr;
      logic [DEF_DATA_W-1:0] data;
   } mem_resp_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// Fixed-depth response delay line. A bubble (valid_i=0) enters as an all-zero
// stage so the payload outputs are 0 whenever out_valid_o is 0.
module mem_resp_pipe
   import mem_if_pkg::*;
#(
   parameter int AW     = DEF_ADDR_W,
   parameter int DW     = DEF_DATA_W,
   parameter int STAGES = DEF_LATENCY - 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] data_i,
   output logic          out_valid_o,
   output logic [AW-1:0] out_addr_o,
   output logic [DW-1:0] out_data_o,
   output logic          any_valid_o
);

   typedef struct packed {
      logic          valid;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } stage_t;

   stage_t stage_q [STAGES];
   stage_t stage_d [STAGES];

   always_comb begin
      stage_d = stage_q;
      stage_d[0] = valid_i ? {1'b1, addr_i, data_i} : '0;
      for (int i = 1; i < STAGES; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   always_comb begin
      any_valid_o = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         any_valid_o = any_valid_o | stage_q[i].valid;
      end
   end

   assign out_valid_o = stage_q[STAGES-1].valid;
   assign out_addr_o  = stage_q[STAGES-1].addr;
   assign out_data_o  = stage_q[STAGES-1].data;

endmodule

// File: rtl/mem_pipelined_responder.sv
// Main-memory responder for the cache fill path: word array with a registered
// read port followed by a fixed-latency response pipeline.
module mem_pipelined_responder
   import mem_if_pkg::*;
#(
   parameter int    ADDR_W    = DEF_ADDR_W,
   parameter int    DATA_W    = DEF_DATA_W,
   parameter int    LATENCY   = DEF_LATENCY,
   parameter int    MEM_WORDS = 32768,
   parameter string INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic [ADDR_W-1:0] resp_addr,
   output logic              busy
);

   // Handshake: no back-pressure. A request is taken on every rising edge where
   // enable=1; each read produces exactly one data_valid pulse LATENCY cycles
   // later, in issue order; writes never produce a response.

   localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
      $error("mem_pipelined_responder: LATENCY must be in 2..8");
   end

   logic [DATA_W-1:0] mem_q [MEM_WORDS];

   logic [31:0]       addr_word;
   logic [IDX_W-1:0]  word_idx;
   logic              rd_valid_d;
   logic              rd_valid_q;
   logic [ADDR_W-1:0] rd_addr_d;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [DATA_W-1:0] rd_data_q;
   logic              pipe_busy;

   always_comb begin
      addr_word  = 32'(addr) >> 1;
      word_idx   = IDX_W'(addr_word % 32'(MEM_WORDS));
      rd_valid_d = enable & ~wr;
      rd_addr_d  = addr & ~ADDR_W'(1);
   end

   // Array port: write and read share the index; a read captures the value
   // present before this edge, so a same-word write in a later cycle cannot leak in.
   always_ff @(posedge clk) begin
      if (enable && wr) mem_q[word_idx] <= data_in;
      if (rd_valid_d)   rd_data_q       <= mem_q[word_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_addr_q  <= rd_addr_d;
      end
   end

   mem_resp_pipe #(
      .AW     (ADDR_W),
      .DW     (DATA_W),
      .STAGES (LATENCY - 1)
   ) u_resp_pipe (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_i     (rd_valid_q),
      .addr_i      (rd_addr_q),
      .data_i      (rd_data_q),
      .out_valid_o (data_valid),
      .out_addr_o  (resp_addr),
      .out_data_o  (data_out),
      .any_valid_o (pipe_busy)
   );

   assign busy = rd_valid_d | rd_valid_q | pipe_busy;

endmodule

// File: tb/tb_mem_pipelined_responder.sv
// Scoreboard bench for mem_pipelined_responder: directed fill/ordering/reset
// scenarios followed by random traffic against a word-array reference model.
module tb_mem_pipelined_responder;
  import mem_if_pkg::*;

  localparam int L         = 4;
  localparam int MEM_WORDS = 32768;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic [15:0] resp_addr;
  logic        busy;

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  mem_pipelined_responder #(
    .ADDR_W(16), .DATA_W(16), .LATENCY(L), .MEM_WORDS(MEM_WORDS), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .resp_addr(resp_addr), .busy(busy)
  );

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          due;
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem_model [int];
  int          n_vec  = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    int   idx;
    exp_t e;
    @(posedge clk); #1;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    idx = int'(a >> 1) % MEM_WORDS;
    if (en && w) begin
      mem_model[idx] = d;
    end else if (en) begin
      e.due  = cycle + L;
      e.data = mem_model.exists(idx) ? mem_model[idx] : 16'hxxxx;
      e.addr = a & 16'hFFFE;
      exp_q.push_back(e);
    end
  endtask

  task automatic wr_word(input logic [15:0] a, input logic [15:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic rd_word(input logic [15:0] a);
    drive(1'b1, 1'b0, a, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Reset drops everything in flight; the array model is left untouched.
  task automatic pulse_reset(input int n);
    @(posedge clk); #1;
    enable = 1'b0;
    wr     = 1'b0;
    rst_n  = 1'b0;
    exp_q.delete();
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  logic mon_exp_valid;
  exp_t mon_e;

  always @(negedge clk) begin
    check("busy", busy, exp_q.size() > 0);
    mon_exp_valid = (exp_q.size() > 0) && (exp_q[0].due == cycle);
    check("data_valid", data_valid, mon_exp_valid);
    if (mon_exp_valid) begin
      mon_e = exp_q.pop_front();
      if (data_valid) begin
        check("data_out", data_out, mon_e.data);
        check("resp_addr", resp_addr, mon_e.addr);
      end
    end
    if (!data_valid) begin
      check("idle_data_out", data_out, 16'h0);
      check("idle_resp_addr", resp_addr, 16'h0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        en_r, w_r;
    logic [15:0] a_r;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write then read the same word on the next cycle.
    wr_word(16'h0010, 16'hBEEF);
    rd_word(16'h0010);
    idle(L + 2);

    // Cache-line fill: preload then 8 back-to-back reads.
    for (int i = 0; i < WORDS_PER_LINE; i++) wr_word(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
    idle(2);
    for (int i = 0; i < WORDS_PER_LINE; i++) rd_word(16'h0100 + 16'(2 * i));
    idle(L + 2);

    // Read captures old data; a later read sees the new write.
    wr_word(16'h0020, 16'h1111);
    idle(1);
    rd_word(16'h0020);
    wr_word(16'h0020, 16'h2222);
    rd_word(16'h0020);
    idle(L + 2);

    // Bubble in the middle of a read stream.
    rd_word(16'h0010);
    idle(1);
    rd_word(16'h0100);
    rd_word(16'h0102);
    idle(L + 2);

    // Reset mid-burst: nothing in flight may surface afterwards.
    for (int i = 0; i < 3; i++) rd_word(16'h0100 + 16'(2 * i));
    pulse_reset(1);
    idle(14);
    for (int i = 0; i < WORDS_PER_LINE; i++) rd_word(16'h0100 + 16'(2 * i));
    idle(L + 2);

    // Odd address and top-of-range word.
    rd_word(16'h0011);
    wr_word(16'h7FFE, 16'h5555);
    wr_word(16'hFFFE, 16'hABCD);
    rd_word(16'hFFFE);
    rd_word(16'h7FFE);
    idle(L + 2);

    // Random traffic over an initialised 64-word region.
    for (int i = 0; i < 64; i++) wr_word(16'h0200 + 16'(2 * i), 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      en_r = ($urandom_range(0, 3) != 0);
      w_r  = ($urandom_range(0, 2) == 0);
      a_r  = 16'h0200 + 16'(2 * $urandom_range(0, 63)) + 16'($urandom_range(0, 1));
      drive(en_r, w_r, a_r, 16'($urandom));
    end
    idle(L + 3);

    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
